// File: rtl/encoder4to2_evt.sv
// encoder4to2_evt: event-driven 4-to-2 encoder.
// Rising edges on req[3:0] become pending events. Each pending event is
// issued as one 2-bit code through a registered valid/ready output stage.
// RR selects the arbitration used when several events are pending:
// 0 = fixed priority (bit 3 highest), 1 = round-robin after the last issued code.
//
// Ports:
//   clk     in   system clock, rising-edge active
//   rst     in   synchronous active-high reset
//   req     in   [3:0] request lines; a 0->1 on bit i is one event for code i
//   ready   in   downstream accepts Y when valid & ready
//   ovf_clr in   clears the sticky ovf flag
//   Y       out  [1:0] code of the issued event (registered)
//   valid   out  Y holds an unconsumed code (registered)
//   pend    out  [3:0] events not yet loaded into Y (registered)
//   ovf     out  sticky: an event was merged into an already-pending one
module encoder4to2_evt #(
  parameter int unsigned RR = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       ready,
  input  logic       ovf_clr,
  output logic [1:0] Y,
  output logic       valid,
  output logic [3:0] pend,
  output logic       ovf
);

  logic [3:0] req_prev;
  logic [3:0] rise;
  logic [3:0] load_sel;
  logic [1:0] last;
  logic [1:0] sel_code;
  logic [1:0] idx;
  logic       found;
  logic       load;

  assign rise = req & ~req_prev;
  assign load = (|pend) & (~valid | ready);

  // Selection looks only at registered pend; a same-cycle rise waits a cycle.
  always_comb begin
    sel_code = '0;
    idx      = '0;
    found    = 1'b0;
    if (RR != 0) begin
      // Walk last+1, last+2, ... wrapping naturally in 2 bits.
      for (int unsigned k = 1; k <= 4; k++) begin
        idx = last + k[1:0];
        if (!found && pend[idx]) begin
          sel_code = idx;
          found    = 1'b1;
        end
      end
    end else begin
      // Ascending scan: the highest set index is the last one written.
      for (int unsigned k = 0; k < 4; k++) begin
        if (pend[k[1:0]]) begin
          sel_code = k[1:0];
        end
      end
    end
  end

  assign load_sel = load ? (4'b0001 << sel_code) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      Y        <= '0;
      valid    <= 1'b0;
      pend     <= '0;
      ovf      <= 1'b0;
      req_prev <= '1;  // lines already high at release are not events
      last     <= '1;  // first round-robin search starts at bit 0
    end else begin
      req_prev <= req;
      // A rise on the bit being loaded re-arms it without overflow.
      pend     <= (pend & ~load_sel) | rise;
      if (|(rise & pend & ~load_sel)) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
      if (load) begin
        Y     <= sel_code;
        valid <= 1'b1;
        if (RR != 0) begin
          last <= sel_code;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_encoder4to2_evt.sv
module tb_encoder4to2_evt;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       ready;
  logic       ovf_clr;

  logic [1:0] y0, y1;
  logic       valid0, valid1, ovf0, ovf1;
  logic [3:0] pend0, pend1;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state, index 0 = fixed priority, 1 = round-robin.
  int m_y[2];
  bit m_valid[2];
  bit m_ovf[2];
  bit m_pend[2][4];
  int m_last[2];
  bit m_prev[4];

  encoder4to2_evt #(.RR(0)) dut_fp (
    .clk(clk), .rst(rst), .req(req), .ready(ready), .ovf_clr(ovf_clr),
    .Y(y0), .valid(valid0), .pend(pend0), .ovf(ovf0)
  );

  encoder4to2_evt #(.RR(1)) dut_rr (
    .clk(clk), .rst(rst), .req(req), .ready(ready), .ovf_clr(ovf_clr),
    .Y(y1), .valid(valid1), .pend(pend1), .ovf(ovf1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pend_val(input int m);
    int v = 0;
    for (int i = 0; i < 4; i++) if (m_pend[m][i]) v += (1 << i);
    return v;
  endfunction

  // Which pending event is issued next under each arbitration rule.
  function automatic int pick(input int m);
    if (m == 0) begin
      for (int i = 3; i >= 0; i--) if (m_pend[0][i]) return i;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        int i = (m_last[1] + k) % 4;
        if (m_pend[1][i]) return i;
      end
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_y[m] = 0; m_valid[m] = 0; m_ovf[m] = 0; m_last[m] = 3;
      for (int i = 0; i < 4; i++) m_pend[m][i] = 0;
    end
    for (int i = 0; i < 4; i++) m_prev[i] = 1;
  endtask

  task automatic model_edge();
    bit r[4];
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 4; i++) r[i] = req[i] && !m_prev[i];
    for (int m = 0; m < 2; m++) begin
      bit any = 0;
      bit load;
      bit lost = 0;
      int s = -1;
      for (int i = 0; i < 4; i++) any |= m_pend[m][i];
      load = any && (!m_valid[m] || ready);
      if (load) s = pick(m);
      for (int i = 0; i < 4; i++) if (r[i] && m_pend[m][i] && i != s) lost = 1;
      if (load) begin
        m_pend[m][s] = 0;
        m_y[m] = s;
        m_valid[m] = 1;
        if (m == 1) m_last[1] = s;
      end else if (m_valid[m] && ready) begin
        m_valid[m] = 0;
      end
      for (int i = 0; i < 4; i++) if (r[i]) m_pend[m][i] = 1;
      if (lost) m_ovf[m] = 1;
      else if (ovf_clr) m_ovf[m] = 0;
    end
    for (int i = 0; i < 4; i++) m_prev[i] = req[i];
  endtask

  task automatic check_all();
    check("fp_Y", int'(y0), m_y[0]);
    check("fp_valid", int'(valid0), int'(m_valid[0]));
    check("fp_pend", int'(pend0), pend_val(0));
    check("fp_ovf", int'(ovf0), int'(m_ovf[0]));
    check("rr_Y", int'(y1), m_y[1]);
    check("rr_valid", int'(valid1), int'(m_valid[1]));
    check("rr_pend", int'(pend1), pend_val(1));
    check("rr_ovf", int'(ovf1), int'(m_ovf[1]));
  endtask

  task automatic step(input bit r, input logic [3:0] q, input bit rd, input bit oc);
    rst = r; req = q; ready = rd; ovf_clr = oc;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int exp_fp[4] = '{3, 2, 1, 0};
    int exp_rr[4] = '{2, 3, 0, 1};

    model_reset();

    // Lines held high across reset release produce no event.
    for (int i = 0; i < 3; i++) step(1, 4'b0101, 1, 0);
    check("rst_Y", int'(y0), 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 4'b0101, 1, 0);
      check("hold_pend", int'(pend0), 0);
      check("hold_valid", int'(valid0), 0);
    end

    // Single event latency.
    step(0, 4'b0000, 1, 0);
    step(0, 4'b0100, 1, 0);
    check("lat_pend", int'(pend0), 4);
    check("lat_valid0", int'(valid0), 0);
    step(0, 4'b0000, 1, 0);
    check("lat_Y", int'(y0), 2);
    check("lat_valid1", int'(valid0), 1);
    step(0, 4'b0000, 1, 0);
    check("lat_valid2", int'(valid0), 0);

    // Fixed priority burst 1011.
    step(0, 4'b1011, 1, 0);
    check("fp_burst_pend", int'(pend0), 11);
    step(0, 4'b1011, 1, 0);
    check("fp_burst_Y3", int'(y0), 3);
    check("fp_burst_p3", int'(pend0), 3);
    step(0, 4'b1011, 1, 0);
    check("fp_burst_Y1", int'(y0), 1);
    check("fp_burst_p1", int'(pend0), 1);
    step(0, 4'b1011, 1, 0);
    check("fp_burst_Y0", int'(y0), 0);
    check("fp_burst_p0", int'(pend0), 0);

    // Round-robin order from last=01 with all four pending.
    step(1, 4'b0000, 0, 0);
    step(0, 4'b0000, 0, 0);
    step(0, 4'b0010, 0, 0);
    step(0, 4'b0010, 0, 0);
    check("rr_first_Y", int'(y1), 1);
    step(0, 4'b0000, 0, 0);
    step(0, 4'b1111, 0, 0);
    check("rr_all_pend", int'(pend1), 15);
    for (int i = 0; i < 4; i++) begin
      step(0, 4'b1111, 1, 0);
      check("rr_order", int'(y1), exp_rr[i]);
      check("fp_order", int'(y0), exp_fp[i]);
    end

    // Backpressure and overflow.
    step(1, 4'b0000, 0, 0);
    step(0, 4'b0000, 0, 0);
    step(0, 4'b0010, 0, 0);
    step(0, 4'b0000, 0, 0);
    check("bp_Y", int'(y0), 1);
    step(0, 4'b0010, 0, 0);
    check("bp_stable_Y", int'(y0), 1);
    check("bp_stable_v", int'(valid0), 1);
    check("bp_pend", int'(pend0), 2);
    step(0, 4'b0000, 0, 0);
    step(0, 4'b0010, 0, 0);
    check("bp_ovf", int'(ovf0), 1);
    step(0, 4'b0000, 1, 0);
    check("bp_Y2", int'(y0), 1);
    check("bp_v2", int'(valid0), 1);
    step(0, 4'b0000, 1, 0);
    check("bp_drain", int'(valid0), 0);
    check("bp_ovf_sticky", int'(ovf0), 1);
    step(0, 4'b0000, 1, 1);
    check("bp_ovf_clr", int'(ovf0), 0);

    // Reset mid-transfer.
    step(0, 4'b0000, 0, 0);
    step(0, 4'b0001, 0, 0);
    step(0, 4'b0000, 0, 0);
    step(0, 4'b0110, 0, 0);
    check("mid_pend", int'(pend0), 6);
    check("mid_valid", int'(valid0), 1);
    step(1, 4'b0110, 1, 0);
    check("mid_rst_v", int'(valid0), 0);
    check("mid_rst_p", int'(pend0), 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 4'b0110, 1, 0);
      check("mid_quiet", int'(valid0), 0);
    end

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, 4'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/encoder4to2_evt.md
Name: encoder4to2_evt

Overview:
- Sequential counterpart of the team's 2-to-4 one-hot decoder: turns four request lines back into a 2-bit code.
- Detects rising edges on req[3:0] and holds each edge as a pending event.
- Emits one 2-bit code per event through a valid/ready output register, arbitrating when several events are pending.
- Sits between button/strobe inputs and downstream logic that consumes codes such as the decoder's A input.

Parameters:
- RR, 0, arbitration mode: 0 = fixed priority (bit 3 highest, bit 0 lowest); 1 = round-robin starting after the last issued code.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request lines; a 0->1 transition on bit i is one event for code i.
- ready  input  1  downstream accepts Y when valid & ready.
- ovf_clr  input  1  clears the ovf flag.
- Y  output  2  encoded index of the issued event; registered.
- valid  output  1  Y holds an unconsumed code; registered.
- pend  output  4  pending-event vector, not yet loaded into Y; registered.
- ovf  output  1  sticky flag: an event was dropped.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Y=2'b00, valid=0, pend=4'b0000, ovf=0.
  - Internal req_prev=4'b1111, so lines held high across reset release produce no event.
  - Round-robin pointer last=2'b11, so the first RR search starts at bit 0.
  - All other inputs are ignored while rst=1. Reset mid-transfer drops all pending and in-flight codes.
- Edge detect: rise = req & ~req_prev; req_prev <= req every cycle.
- Pending update, per bit i, each edge:
  - pend[i] <= (pend[i] & ~load_sel[i]) | rise[i].
  - load_sel is the one-hot bit chosen for loading this cycle (0 if no load).
- Overflow: rise[i] & pend[i] & ~load_sel[i] sets ovf; the event is merged and effectively lost.
  - ovf_clr=1 clears ovf. If ovf_clr and a new overflow occur in the same cycle, the overflow wins (ovf stays 1).
- Load condition: load = (|pend) & (~valid | ready).
  - On load: Y <= encode(sel), valid <= 1, and in RR mode last <= encode(sel).
- No load and valid & ready: valid <= 0 and Y holds its value.
- Backpressure: while valid & ~ready, Y and valid are stable and pend keeps accumulating.
- Selection, computed from registered pend only (no same-cycle bypass from req):
  - RR=0: the highest set index wins.
  - RR=1: search indices last+1, last+2, ... modulo 4; the first set bit wins, with wrap-around 3->0.
- Latency: rising edge sampled at edge k sets pend at k; with the output register free, Y/valid appear after edge k+1 (2 cycles from req rising).
- Throughput: 1 code per cycle when ready=1 continuously.
- Simultaneous events:
  - Multiple rises in one cycle all become pending.
  - A rise on the bit being loaded that cycle re-arms pend[i] with no overflow.
  - A rise on the bit whose code currently sits in Y is a new, legal event.
- Falling edges and held-high levels produce nothing.

Test Plan:
- Reset release with req=4'b0101 held high -> no event; pend=0000, valid=0 for 10 cycles.
- req 0000->0100 for one cycle, ready=1 -> pend=0100 after edge k; Y=2'b10, valid=1 after edge k+1; valid=0 one cycle later.
- RR=0, req 0000->1011 in one cycle, ready=1 -> codes 11, 01, 00 on three consecutive cycles; pend walks 1011->0011->0001->0000.
- RR=1, pend=1111 with last=01 -> issue order 10, 11, 00, 01.
- Backpressure: ready=0 with Y=01 valid, new rise on bit 1 -> Y/valid stable, pend=0010. A second rise on bit 1 before any load -> ovf=1. ready=1 -> Y=01 twice total. ovf_clr -> ovf=0.
- rst asserted while valid=1 and pend=0110 -> next cycle valid=0, Y=00, pend=0000; no codes emitted afterwards.
